// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multState_t;

  // Number of bits needed to count 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int width;
    int span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span * 2;
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand magnitudes, radix-2 add/shift accumulator and signed result register.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           loadOps,
  input  logic           doStep,
  input  logic           lastStep,
  input  logic           negate,
  input  logic           inSigned,
  input  logic [N-1:0]   inputA,
  input  logic [N-1:0]   inputB,
  output logic [2*N-1:0] result
);

  logic [N-1:0]   magA;
  logic [N-1:0]   magB;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N:0]   acc;
  logic [2*N:0]   addend;
  logic [2*N:0]   accSum;
  logic [2*N:0]   accShift;
  logic [2*N-1:0] prodMag;

  // Operand magnitudes; the most negative value maps to 2^(N-1), which still fits in N bits.
  always_comb begin
    magA = (inSigned && inputA[N-1]) ? -inputA : inputA;
    magB = (inSigned && inputB[N-1]) ? -inputB : inputB;
  end

  // One radix-2 step: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    addend   = mplier[0] ? {1'b0, mcand, {N{1'b0}}} : '0;
    accSum   = acc + addend;
    accShift = accSum >> 1;
    prodMag  = accShift[2*N-1:0];
  end

  // Operand capture, per-cycle accumulation and the final signed result write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else if (loadOps) begin
      mcand  <= magA;
      mplier <= magB;
      acc    <= '0;
    end else if (doStep) begin
      acc    <= accShift;
      mplier <= mplier >> 1;
      if (lastStep) begin
        result <= negate ? -prodMag : prodMag;
      end
    end
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Handshaked sequential multiplier: FSM, step counter, sign capture and datapath instance.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [N-1:0]   inputA,
  input  logic [N-1:0]   inputB,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic           busy
);

  localparam int CntW = clog2(N);

  multState_t    state;
  multState_t    nextState;
  logic [CntW-1:0] bitCnt;
  logic          signFlag;
  logic          loadOps;
  logic          doStep;
  logic          lastStep;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    nextState = state;
    loadOps   = 1'b0;
    doStep    = 1'b0;
    lastStep  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          loadOps   = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        doStep = 1'b1;
        if (bitCnt == CntW'(N - 1)) begin
          lastStep  = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Step counter and product sign, both captured on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitCnt   <= '0;
      signFlag <= 1'b0;
    end else if (loadOps) begin
      bitCnt   <= '0;
      signFlag <= in_signed & (inputA[N-1] ^ inputB[N-1]);
    end else if (doStep) begin
      bitCnt   <= bitCnt + CntW'(1);
    end
  end

  // Handshake outputs decode from state only, forced low while reset is asserted.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE) && !reset;
    busy      = (state != IDLE);
  end

  seq_mult_datapath #(.N(N)) datapath (
    .clk      (clk),
    .reset    (reset),
    .loadOps  (loadOps),
    .doStep   (doStep),
    .lastStep (lastStep),
    .negate   (signFlag),
    .inSigned (in_signed),
    .inputA   (inputA),
    .inputB   (inputB),
    .result   (result)
  );

endmodule
